// File: rtl/ysyx_23060025_axi_master_if.sv
// Signal bundle between the CPU-side request/response port, the AXI-lite master and its slave.
// The master modport is the bridge's view; the slave modport is the CPU plus memory environment.
interface ysyx_23060025_axi_master_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  localparam int STRB_LEN = DATA_LEN / 8;

  logic                req_valid_i;
  logic                req_ready_o;
  logic                req_wen_i;
  logic [ADDR_LEN-1:0] req_addr_i;
  logic [DATA_LEN-1:0] req_wdata_i;
  logic [STRB_LEN-1:0] req_wmask_i;

  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_LEN-1:0] rsp_rdata_o;
  logic                rsp_err_o;

  logic [ADDR_LEN-1:0] addr_r_addr_o;
  logic                addr_r_valid_o;
  logic                addr_r_ready_i;
  logic [DATA_LEN-1:0] r_data_i;
  logic [1:0]          r_resp_i;
  logic                r_valid_i;
  logic                r_ready_o;

  logic [ADDR_LEN-1:0] addr_w_addr_o;
  logic                addr_w_valid_o;
  logic                addr_w_ready_i;
  logic [DATA_LEN-1:0] w_data_o;
  logic [STRB_LEN-1:0] w_strb_o;
  logic                w_valid_o;
  logic                w_ready_i;
  logic [1:0]          bkwd_resp_i;
  logic                bkwd_valid_i;
  logic                bkwd_ready_o;

  modport master (
    input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output addr_r_addr_o, addr_r_valid_o, r_ready_o,
    input  addr_r_ready_i, r_data_i, r_resp_i, r_valid_i,
    output addr_w_addr_o, addr_w_valid_o, w_data_o, w_strb_o, w_valid_o, bkwd_ready_o,
    input  addr_w_ready_i, w_ready_i, bkwd_resp_i, bkwd_valid_i
  );

  modport slave (
    output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  addr_r_addr_o, addr_r_valid_o, r_ready_o,
    output addr_r_ready_i, r_data_i, r_resp_i, r_valid_i,
    input  addr_w_addr_o, addr_w_valid_o, w_data_o, w_strb_o, w_valid_o, bkwd_ready_o,
    output addr_w_ready_i, w_ready_i, bkwd_resp_i, bkwd_valid_i
  );
endinterface

// File: rtl/ysyx_23060025_axi_master.sv
// Single-outstanding CPU request to AXI-lite master bridge: one read or one write
// per request, response held on the CPU side until consumed.
module ysyx_23060025_axi_master #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_23060025_axi_master_if.master   bus,
  output logic [2:0]                   dbg_state,
  output logic                         dbg_wen
);
  localparam int STRB_LEN = DATA_LEN / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                ready_en;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [STRB_LEN-1:0] wmask_q;
  logic                wen_q;
  logic                aw_done, w_done;
  logic [DATA_LEN-1:0] rdata_q;
  logic                err_q;

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid && ready; every valid here is a function of state/flags only, never of
  // the matching ready, so valid and payload stay put until that edge.
  logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, rsp_hs;

  assign bus.req_ready_o    = (state_q == IDLE) && ready_en;
  assign bus.addr_r_valid_o = (state_q == RADDR);
  assign bus.r_ready_o      = (state_q == RDATA);
  assign bus.addr_w_valid_o = (state_q == WRITE) && !aw_done;
  assign bus.w_valid_o      = (state_q == WRITE) && !w_done;
  assign bus.bkwd_ready_o   = (state_q == WRESP);
  assign bus.rsp_valid_o    = (state_q == DONE);

  assign bus.addr_r_addr_o = addr_q;
  assign bus.addr_w_addr_o = addr_q;
  assign bus.w_data_o      = wdata_q;
  assign bus.w_strb_o      = wmask_q;
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_err_o     = err_q;

  assign accept = bus.req_valid_i && bus.req_ready_o;
  assign ar_hs  = bus.addr_r_valid_o && bus.addr_r_ready_i;
  assign r_hs   = bus.r_ready_o && bus.r_valid_i;
  assign aw_hs  = bus.addr_w_valid_o && bus.addr_w_ready_i;
  assign w_hs   = bus.w_valid_o && bus.w_ready_i;
  assign b_hs   = bus.bkwd_ready_o && bus.bkwd_valid_i;
  assign rsp_hs = bus.rsp_valid_o && bus.rsp_ready_i;

  assign dbg_state = state_q;
  assign dbg_wen   = wen_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.req_wen_i ? WRITE : RADDR;
      RADDR:   if (ar_hs) state_d = RDATA;
      RDATA:   if (r_hs) state_d = DONE;
      // Either channel may finish first, or both on the same edge.
      WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WRESP;
      WRESP:   if (b_hs) state_d = DONE;
      DONE:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_en <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_en <= 1'b1;
      if (accept) begin
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        wmask_q <= bus.req_wmask_i;
        wen_q   <= bus.req_wen_i;
      end
      if (state_q == WRITE && state_d == WRITE) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (r_hs) begin
        rdata_q <= bus.r_data_i;
        err_q   <= (bus.r_resp_i != 2'b00);
      end else if (b_hs) begin
        rdata_q <= '0;
        err_q   <= (bus.bkwd_resp_i != 2'b00);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060025_axi_master.sv
// Directed bench for the AXI-lite master: vector table of single transactions
// against a zero-wait slave, plus split-write, backpressure and mid-op reset sequences.
module tb_ysyx_23060025_axi_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  logic       dbg_wen;
  int         n_checks = 0;
  int         n_errors = 0;

  ysyx_23060025_axi_master_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  ysyx_23060025_axi_master #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_wen   (dbg_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] sdata;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.addr_r_ready_i = 1'b0;
    bus.r_data_i       = '0;
    bus.r_resp_i       = '0;
    bus.r_valid_i      = 1'b0;
    bus.addr_w_ready_i = 1'b0;
    bus.w_ready_i      = 1'b0;
    bus.bkwd_resp_i    = '0;
    bus.bkwd_valid_i   = 1'b0;
    bus.rsp_ready_i    = 1'b0;
  endtask

  task automatic request(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
    bus.req_wen_i   = wen;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_wmask_i = wmask;
    bus.req_valid_i = 1'b1;
  endtask

  // One transaction against a slave that is always ready and always valid.
  task automatic run_vec(input vec_t v, input int idx);
    bus.addr_r_ready_i = 1'b1;
    bus.r_valid_i      = 1'b1;
    bus.r_data_i       = v.sdata;
    bus.r_resp_i       = v.sresp;
    bus.addr_w_ready_i = 1'b1;
    bus.w_ready_i      = 1'b1;
    bus.bkwd_valid_i   = 1'b1;
    bus.bkwd_resp_i    = v.sresp;
    bus.rsp_ready_i    = 1'b0;
    request(v.wen, v.addr, v.wdata, v.wmask);
    check($sformatf("v%0d_req_ready_idle", idx), 32'(bus.req_ready_o), 32'd1);
    step();
    bus.req_valid_i = 1'b0;
    check($sformatf("v%0d_req_ready_busy", idx), 32'(bus.req_ready_o), 32'd0);
    if (!v.wen) begin
      check($sformatf("v%0d_ar_valid", idx), 32'(bus.addr_r_valid_o), 32'd1);
      check($sformatf("v%0d_ar_addr", idx), bus.addr_r_addr_o, v.addr);
      check($sformatf("v%0d_aw_valid_rd", idx), 32'(bus.addr_w_valid_o), 32'd0);
      step();
      check($sformatf("v%0d_r_ready", idx), 32'(bus.r_ready_o), 32'd1);
      step();
    end else begin
      check($sformatf("v%0d_aw_valid", idx), 32'(bus.addr_w_valid_o), 32'd1);
      check($sformatf("v%0d_w_valid", idx), 32'(bus.w_valid_o), 32'd1);
      check($sformatf("v%0d_aw_addr", idx), bus.addr_w_addr_o, v.addr);
      check($sformatf("v%0d_w_data", idx), bus.w_data_o, v.wdata);
      check($sformatf("v%0d_w_strb", idx), 32'(bus.w_strb_o), 32'(v.wmask));
      step();
      check($sformatf("v%0d_aw_drop", idx), 32'(bus.addr_w_valid_o), 32'd0);
      check($sformatf("v%0d_w_drop", idx), 32'(bus.w_valid_o), 32'd0);
      check($sformatf("v%0d_b_ready", idx), 32'(bus.bkwd_ready_o), 32'd1);
      step();
    end
    check($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid_o), 32'd1);
    check($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
    check($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err_o), 32'(v.exp_err));
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    check($sformatf("v%0d_rsp_done", idx), 32'(bus.rsp_valid_o), 32'd0);
    check($sformatf("v%0d_back_idle", idx), 32'(bus.req_ready_o), 32'd1);
    slave_idle();
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 32'h0,         2'd0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h8000_0003, 32'h0,         4'h0, 32'h0000_00A5, 2'd2, 32'h0000_00A5, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h0, 32'h0,         2'd3, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0,         4'h5, 32'h0,         2'd0, 32'h0,         1'b0};

    slave_idle();
    bus.req_valid_i = 1'b0;
    bus.req_wen_i   = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wmask_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_ar_valid", 32'(bus.addr_r_valid_o), 32'd0);
    check("rst_aw_valid", 32'(bus.addr_w_valid_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    check("rel_req_ready_before_edge", 32'(bus.req_ready_o), 32'd0);
    step();
    check("rel_req_ready_after_edge", 32'(bus.req_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Split write: AW accepted at +1, W at +3
    slave_idle();
    request(1'b1, 32'h8000_0040, 32'hA5A5_0F0F, 4'h3);
    step();
    bus.req_valid_i = 1'b0;
    check("sw_p1_aw", 32'(bus.addr_w_valid_o), 32'd1);
    check("sw_p1_w", 32'(bus.w_valid_o), 32'd1);
    bus.addr_w_ready_i = 1'b1;
    step();
    bus.addr_w_ready_i = 1'b0;
    check("sw_p2_aw_drop", 32'(bus.addr_w_valid_o), 32'd0);
    check("sw_p2_w_held", 32'(bus.w_valid_o), 32'd1);
    check("sw_p2_b_ready", 32'(bus.bkwd_ready_o), 32'd0);
    step();
    check("sw_p3_w_held", 32'(bus.w_valid_o), 32'd1);
    check("sw_p3_w_data", bus.w_data_o, 32'hA5A5_0F0F);
    check("sw_p3_w_strb", 32'(bus.w_strb_o), 32'h3);
    bus.w_ready_i = 1'b1;
    step();
    bus.w_ready_i = 1'b0;
    check("sw_p4_w_drop", 32'(bus.w_valid_o), 32'd0);
    check("sw_p4_b_ready", 32'(bus.bkwd_ready_o), 32'd1);
    bus.bkwd_valid_i = 1'b1;
    step();
    bus.bkwd_valid_i = 1'b0;
    check("sw_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("sw_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;

    // Backpressure on AR and on the CPU response
    request(1'b0, 32'h8000_0080, 32'h0, 4'h0);
    step();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_ar_valid_%0d", i), 32'(bus.addr_r_valid_o), 32'd1);
      check($sformatf("bp_ar_addr_%0d", i), bus.addr_r_addr_o, 32'h8000_0080);
      check($sformatf("bp_req_ready_%0d", i), 32'(bus.req_ready_o), 32'd0);
      step();
    end
    bus.addr_r_ready_i = 1'b1;
    step();
    bus.addr_r_ready_i = 1'b0;
    bus.r_valid_i = 1'b1;
    bus.r_data_i  = 32'h5A5A_1234;
    step();
    bus.r_data_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_rsp_valid_%0d", i), 32'(bus.rsp_valid_o), 32'd1);
      check($sformatf("bp_rsp_rdata_%0d", i), bus.rsp_rdata_o, 32'h5A5A_1234);
      check($sformatf("bp_rsp_req_ready_%0d", i), 32'(bus.req_ready_o), 32'd0);
      step();
    end
    bus.rsp_ready_i = 1'b1;
    step();
    slave_idle();
    check("bp_back_idle", 32'(bus.req_ready_o), 32'd1);

    // Reset during RDATA
    request(1'b0, 32'h8000_0020, 32'h0, 4'h0);
    step();
    bus.req_valid_i    = 1'b0;
    bus.addr_r_ready_i = 1'b1;
    step();
    bus.addr_r_ready_i = 1'b0;
    check("mr_in_rdata", 32'(bus.r_ready_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_r_ready", 32'(bus.r_ready_o), 32'd0);
    check("mr_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("mr_ar_addr", bus.addr_r_addr_o, 32'd0);
    check("mr_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("mr_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("mr_state", 32'(dbg_state), 32'd0);
    step();
    step();
    rst = 1'b0;
    bus.r_valid_i = 1'b1;
    bus.r_data_i  = 32'h1111_2222;
    step();
    check("mr_release_ready", 32'(bus.req_ready_o), 32'd1);
    step();
    check("mr_no_stale_rsp", 32'(bus.rsp_valid_o), 32'd0);
    check("mr_stray_r_ignored", bus.rsp_rdata_o, 32'd0);
    slave_idle();
    run_vec(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_23060025_axi_master.md
YSYX_23060025_AXI_MASTER -- requirements
Module: ysyx_23060025_AXI_MASTER

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, data width; strobe width is DATA_LEN/8.
REQ-003 SHALL have port clk  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have CPU-side request ports:
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle.
- req_wen_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_LEN  byte address.
- req_wdata_i  in  DATA_LEN  write data.
- req_wmask_i  in  4  byte enables.
REQ-006 SHALL have CPU-side response ports:
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_LEN  read data.
- rsp_err_o  out  1  nonzero AXI resp.
REQ-007 SHALL have AXI-lite read ports:
- addr_r_addr_o  out  ADDR_LEN
- addr_r_valid_o  out  1
- addr_r_ready_i  in  1
- r_data_i  in  DATA_LEN
- r_resp_i  in  2
- r_valid_i  in  1
- r_ready_o  out  1
REQ-008 SHALL have AXI-lite write ports:
- addr_w_addr_o  out  ADDR_LEN
- addr_w_valid_o  out  1
- addr_w_ready_i  in  1
- w_data_o  out  DATA_LEN
- w_strb_o  out  4
- w_valid_o  out  1
- w_ready_i  in  1
- bkwd_resp_i  in  2
- bkwd_valid_i  in  1
- bkwd_ready_o  out  1

Function
REQ-009 SHALL implement FSM states IDLE, RADDR, RDATA, WRITE, WRESP, DONE; one transaction outstanding at most.
REQ-010 SHALL drive req_ready_o=1 only in IDLE; acceptance = req_valid_i&req_ready_o; on acceptance register addr, wdata, wmask, wen.
REQ-011 SHALL transition IDLE->RADDR (wen=0) or IDLE->WRITE (wen=1) on acceptance; otherwise stay in IDLE.
REQ-012 SHALL assert addr_r_valid_o only in RADDR with the registered address; move to RDATA on addr_r_ready_i.
REQ-013 SHALL assert r_ready_o only in RDATA; on r_valid_i capture r_data_i into rsp_rdata_o and set rsp_err_o=(r_resp_i!=0); go to DONE.
REQ-014 SHALL, on entry to WRITE, assert addr_w_valid_o and w_valid_o in the same cycle, carrying the registered addr, wdata and wmask.
REQ-015 SHALL track aw_done and w_done flags in WRITE; each valid drops the cycle after its own handshake; move to WRESP once both handshakes are complete, including the case where both complete in the same cycle.
REQ-016 SHALL assert bkwd_ready_o only in WRESP; on bkwd_valid_i set rsp_err_o=(bkwd_resp_i!=0) and rsp_rdata_o=0; go to DONE.
REQ-017 SHALL assert rsp_valid_o only in DONE, holding rsp_rdata_o/rsp_err_o stable until rsp_ready_i; then return to IDLE.
REQ-018 SHALL never make any AXI valid depend combinationally on the matching ready; once asserted, a valid and its payload SHALL stay stable until handshake.
REQ-019 SHALL pass req_addr_i unmodified; alignment is the slave's responsibility.
REQ-020 SHALL issue a write with w_strb_o=0 when req_wmask_i=0; no special casing.
REQ-021 SHALL treat the unused state encoding as IDLE on the next edge.
REQ-022 SHALL ignore r_valid_i/bkwd_valid_i outside RDATA/WRESP.
REQ-023 SHALL, against a zero-wait slave, give a read latency of 3 cycles from acceptance to rsp_valid_o: RADDR at +1, RDATA at +2, DONE at +3.

Reset
REQ-024 SHALL, while rst=1, immediately force state IDLE, clear all AXI valid/ready outputs, rsp_valid_o, rsp_err_o, rsp_rdata_o, aw_done and w_done, and clear the registered request to 0.
REQ-025 SHALL hold req_ready_o=0 while rst=1 and assert it from the first clk edge after release.
REQ-026 SHALL abandon any in-flight transaction on reset; no response is produced for it.

Verification
REQ-027 Read: req addr=0x80000004, wen=0; slave returns 0xDEADBEEF with resp 0 -> addr_r_addr_o=0x80000004, rsp_valid_o at +3, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
REQ-028 Write: addr=0x80000010, wdata=0x12345678, wmask=0xF -> AW and W valid together, strb=0xF, rsp_valid_o after B, rsp_rdata_o=0, rsp_err_o=0.
REQ-029 Split write: addr_w_ready_i at +1, w_ready_i at +3 -> addr_w_valid_o drops at +2, w_valid_o held to +3, bkwd_ready_o from +4.
REQ-030 Backpressure: addr_r_ready_i low 5 cycles, rsp_ready_i low 3 cycles -> addr and response payloads stable throughout; req_ready_o=0 until return to IDLE.
REQ-031 Error: r_resp_i=2 on a read, then bkwd_resp_i=3 on a write -> rsp_err_o=1 for each response.
REQ-032 Reset mid-op: assert rst during RDATA -> all outputs 0 in the same cycle; after release, req_ready_o=1 and a new read completes normally.
